// File: rtl/barcode_pkg.sv
// Shared types and constants for the station barcode receiver.
package barcode_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    SAMPLE    = 3'd3,
    DONE      = 3'd4
  } bc_state_t;

  localparam int ID_BITS     = 8;
  localparam int ID_RSVD_MSB = 7;
  localparam int ID_RSVD_LSB = 6;

  // A station ID is only valid when its two reserved MSBs are clear.
  function automatic logic id_is_valid(input logic [ID_BITS-1:0] id);
    return (id[ID_RSVD_MSB:ID_RSVD_LSB] == 2'b00);
  endfunction

endpackage

// File: rtl/barcode_id_rx_sync.sv
// Two-flop synchronizer for the raw sensor line plus edge detection.
// The line idles high, so everything resets high to avoid a false edge.
module barcode_id_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic bc,
  output logic bc_s,
  output logic fall,
  output logic rise
);

  logic bc_meta;
  logic bc_prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc_meta <= 1'b1;
      bc_s    <= 1'b1;
      bc_prev <= 1'b1;
    end else begin
      bc_meta <= bc;
      bc_s    <= bc_meta;
      bc_prev <= bc_s;
    end
  end

  assign fall = bc_prev & ~bc_s;
  assign rise = ~bc_prev & bc_s;

endmodule

// File: rtl/barcode_id_rx.sv
// Station barcode receiver: measures the start-bit low time as the bit
// period, then samples each data bit one period after its falling edge.
module barcode_id_rx
  import barcode_pkg::*;
#(
  parameter int PERIOD_W   = 22,
  parameter int MIN_PERIOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         BC,
  input  logic         clr_ID_vld,
  output logic [7:0]   ID,
  output logic         ID_vld,
  output logic         busy
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_MIN = PERIOD_W'(MIN_PERIOD);

  bc_state_t             state, state_nxt;
  logic [PERIOD_W-1:0]   cnt, period_q;
  logic [3:0]            bit_cnt;
  logic [ID_BITS-1:0]    shift_reg;
  logic                  bc_s, fall, rise;
  logic                  cnt_sat;

  // Datapath strobes from the FSM.
  logic cnt_one, cnt_zero, cnt_inc, cap_period, shift_en, load_id;

  barcode_id_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .bc   (BC),
    .bc_s (bc_s),
    .fall (fall),
    .rise (rise)
  );

  assign cnt_sat = (cnt == CNT_MAX);
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt  = state;
    cnt_one    = 1'b0;
    cnt_zero   = 1'b0;
    cnt_inc    = 1'b0;
    cap_period = 1'b0;
    shift_en   = 1'b0;
    load_id    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          cnt_one   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (rise) begin
          if (cnt >= CNT_MIN) begin
            cap_period = 1'b1;
            cnt_zero   = 1'b1;
            state_nxt  = WAIT_FALL;
          end else begin
            state_nxt  = IDLE;
          end
        end else if (cnt_sat) begin
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          cnt_one   = 1'b1;
          state_nxt = SAMPLE;
        end else if (cnt_sat) begin
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SAMPLE: begin
        // Edges here are ignored; only the period count matters.
        if (cnt == period_q) begin
          shift_en  = 1'b1;
          cnt_zero  = 1'b1;
          state_nxt = (bit_cnt == 4'd7) ? DONE : WAIT_FALL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        load_id   = id_is_valid(shift_reg);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period/bit counters and shift register; counters saturate, never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      period_q  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (cnt_one)                  cnt <= PERIOD_W'(1);
      else if (cnt_zero)            cnt <= '0;
      else if (cnt_inc && !cnt_sat) cnt <= cnt + 1'b1;
      if (cap_period) begin
        period_q <= cnt;
        bit_cnt  <= '0;
      end else if (shift_en) begin
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (shift_en) shift_reg <= {shift_reg[ID_BITS-2:0], bc_s};
    end
  end

  // Output ID and sticky valid; a new ID beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID     <= '0;
      ID_vld <= 1'b0;
    end else begin
      if (load_id) begin
        ID     <= shift_reg;
        ID_vld <= 1'b1;
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end
    end
  end

endmodule
